// File: rtl/router_dispatch_queue.sv
// ---------------------------------------------------------------------------
// router_dispatch_queue
//
// Input-side buffer and dispatch stage placed in front of the router's
// parametric demux. Incoming messages are held in a small circular FIFO;
// the head entry is presented to the demux together with its destination
// index, taken from the top bits of the message. The head leaves the
// queue only when the addressed output reports ready, so a stalled head
// blocks every entry behind it and ordering is never changed.
//
// Optional feature (compile-time macro ROUTER_DISPATCH_BYPASS_EN):
//   When defined, an empty queue forwards recv_msg straight to send_*
//   in the same cycle. If the addressed output is ready, the message goes
//   through without being written to the queue; otherwise it is written
//   normally. recv_rdy stays based only on occupancy.
//
// Parameters:
//   p_nbits    - message width in bits (> $clog2(p_noutputs))
//   p_noutputs - number of demux outputs (>= 2)
//   p_depth    - FIFO entries (power of two, >= 2)
//
// Ports:
//   clk      in   clock, all state updates on posedge
//   reset    in   synchronous active-low reset
//   recv_msg in   incoming message, destination in its top bits
//   recv_val in   upstream valid
//   recv_rdy out  queue can accept (occupancy based only)
//   send_msg out  head message to demux (zero when nothing to send)
//   send_sel out  head destination to demux select (zero when idle)
//   send_val out  head valid
//   send_rdy in   per-output ready from the downstream consumers
//   count    out  current occupancy
// ---------------------------------------------------------------------------
module router_dispatch_queue #(
    parameter int p_nbits    = 32,
    parameter int p_noutputs = 8,
    parameter int p_depth    = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [p_nbits-1:0]              recv_msg,
    input  logic                            recv_val,
    output logic                            recv_rdy,
    output logic [p_nbits-1:0]              send_msg,
    output logic [$clog2(p_noutputs)-1:0]   send_sel,
    output logic                            send_val,
    input  logic [p_noutputs-1:0]           send_rdy,
    output logic [$clog2(p_depth):0]        count
);

    localparam int sel_w    = $clog2(p_noutputs);
    localparam int ptr_w    = $clog2(p_depth);
    localparam int cnt_w    = ptr_w + 1;
    localparam int sel_span = 1 << sel_w;

    logic [p_nbits-1:0]  entries [p_depth];
    logic [ptr_w-1:0]    head;
    logic [ptr_w-1:0]    tail;
    logic [cnt_w-1:0]    occ;

    logic                empty;
    logic [p_nbits-1:0]  head_msg;
    logic [sel_span-1:0] rdy_padded;
    logic                fire;
    logic                enq;
    logic                deq;
    logic                wr;

    assign empty    = (occ == '0);
    assign head_msg = entries[head];
    assign recv_rdy = (occ != cnt_w'(p_depth));
    assign count    = occ;

    // Select codes beyond the last real output (non-power-of-two output
    // counts) land on zero-padded ready bits, so such a head never leaves.
    assign rdy_padded = sel_span'(send_rdy);

    // Head presentation. An idle queue drives zeros so the demux outputs
    // stay all-zero rather than showing stale storage.
    always_comb begin
        send_val = !empty;
        send_msg = '0;
        send_sel = '0;
        if (!empty) begin
            send_msg = head_msg;
            send_sel = head_msg[p_nbits-1 -: sel_w];
        end
`ifdef ROUTER_DISPATCH_BYPASS_EN
        if (empty && recv_val) begin
            send_val = 1'b1;
            send_msg = recv_msg;
            send_sel = recv_msg[p_nbits-1 -: sel_w];
        end
`endif
    end

    assign fire = send_val && rdy_padded[send_sel];
    assign enq  = recv_val && recv_rdy;
    assign deq  = fire && !empty;

    // A bypassed message that the demux takes immediately is never stored.
`ifdef ROUTER_DISPATCH_BYPASS_EN
    assign wr = enq && !(fire && empty);
`else
    assign wr = enq;
`endif

    // Pointer and occupancy bookkeeping. Pointers are exactly ptr_w bits so
    // they wrap on their own at p_depth.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (wr) begin
                tail <= tail + ptr_w'(1);
            end
            if (deq) begin
                head <= head + ptr_w'(1);
            end
            case ({wr, deq})
                2'b10:   occ <= occ + cnt_w'(1);
                2'b01:   occ <= occ - cnt_w'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Message storage is left uncleared on reset; the pointers alone decide
    // what is valid.
    always_ff @(posedge clk) begin
        if (wr) begin
            entries[tail] <= recv_msg;
        end
    end

endmodule

// File: tb/tb_router_dispatch_queue.sv
// ---------------------------------------------------------------------------
// tb_router_dispatch_queue
//
// Self-checking bench for router_dispatch_queue with 8-bit messages,
// 4 outputs and 4 entries (destination = msg[7:6]).
// The driver keeps a queue-based reference of the FIFO contents and pushes
// every message it expects to leave the block into a scoreboard. A
// separate monitor, sampling on the falling edge, pops the scoreboard each
// time the block presents a message that the addressed output accepts, and
// also compares the flow-control outputs against the reference.
// ---------------------------------------------------------------------------
module tb_router_dispatch_queue;

    logic       clk;
    logic       reset;
    logic [7:0] recv_msg;
    logic       recv_val;
    logic       recv_rdy;
    logic [7:0] send_msg;
    logic [1:0] send_sel;
    logic       send_val;
    logic [3:0] send_rdy;
    logic [2:0] count;

    int errors;
    int checks;
    bit monitorOn;

    logic [7:0] mq [$];
    logic [7:0] sb [$];

    router_dispatch_queue #(
        .p_nbits   (8),
        .p_noutputs(4),
        .p_depth   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .recv_msg(recv_msg),
        .recv_val(recv_val),
        .recv_rdy(recv_rdy),
        .send_msg(send_msg),
        .send_sel(send_sel),
        .send_val(send_val),
        .send_rdy(send_rdy),
        .count   (count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advances the reference by one clock edge using the inputs that were
    // applied during the cycle that just ended.
    task automatic updateModel();
        bit empty;
        bit doDeq;
        bit doEnq;
        if (!reset) begin
            mq.delete();
            sb.delete();
            return;
        end
        empty = (mq.size() == 0);
        doDeq = !empty && send_rdy[mq[0][7:6]];
        doEnq = recv_val && (mq.size() != 4);
`ifdef ROUTER_DISPATCH_BYPASS_EN
        if (empty && recv_val && send_rdy[recv_msg[7:6]]) doEnq = 1'b0;
`endif
        if (doDeq) void'(mq.pop_front());
        if (doEnq) mq.push_back(recv_msg);
    endtask

    // Drives one cycle of inputs; anything the queue will accept goes into
    // the scoreboard before the edge that takes it.
    task automatic applyStimulus(input bit v, input logic [7:0] m, input logic [3:0] r);
        recv_val = v;
        recv_msg = m;
        send_rdy = r;
        if (reset && v && mq.size() != 4) sb.push_back(m);
        @(posedge clk);
        #1;
        updateModel();
    endtask

    task automatic doReset();
        reset    = 1'b0;
        recv_val = 1'b0;
        recv_msg = 8'h00;
        send_rdy = 4'b0000;
        @(posedge clk);
        #1;
        updateModel();
        reset = 1'b1;
    endtask

    // Monitor: mid-cycle comparison of outputs against the reference, and
    // scoreboard pop for every message the downstream side accepts.
    always @(negedge clk) begin : monitor
        logic [7:0] expMsg;
        bit         expVal;
        bit         bypassNow;
        if (monitorOn && reset) begin
            bypassNow = 1'b0;
`ifdef ROUTER_DISPATCH_BYPASS_EN
            bypassNow = (mq.size() == 0) && recv_val;
`endif
            expVal = (mq.size() != 0) || bypassNow;
            checkOutput("count", 32'(count), 32'(mq.size()));
            checkOutput("recv_rdy", 32'(recv_rdy), 32'(mq.size() != 4));
            checkOutput("send_val", 32'(send_val), 32'(expVal));
            if (mq.size() != 0) begin
                checkOutput("head_msg", 32'(send_msg), 32'(mq[0]));
            end else if (bypassNow) begin
                checkOutput("bypass_msg", 32'(send_msg), 32'(recv_msg));
            end else begin
                checkOutput("idle_msg", 32'(send_msg), 32'h0);
                checkOutput("idle_sel", 32'(send_sel), 32'h0);
            end
            if (send_val && send_rdy[send_sel]) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_unexpected_output", 32'(send_msg), 32'hFFFF_FFFF);
                end else begin
                    expMsg = sb.pop_front();
                    checkOutput("sb_msg", 32'(send_msg), 32'(expMsg));
                    checkOutput("sb_sel", 32'(send_sel), 32'(expMsg[7:6]));
                end
            end
        end
    end

    initial begin
        errors    = 0;
        checks    = 0;
        monitorOn = 1'b0;
        reset     = 1'b0;
        recv_val  = 1'b0;
        recv_msg  = 8'h00;
        send_rdy  = 4'b0000;

        doReset();
        doReset();
        monitorOn = 1'b1;

        // Idle after reset.
        applyStimulus(0, 8'h00, 4'b0000);
        applyStimulus(0, 8'h00, 4'b0000);

        // Single entry stalls, then leaves on the first ready edge.
        applyStimulus(1, 8'h41, 4'b0000);
        applyStimulus(0, 8'h00, 4'b0000);
        applyStimulus(0, 8'h00, 4'b1101);
        applyStimulus(0, 8'h00, 4'b0010);
        applyStimulus(0, 8'h00, 4'b0000);

        // Fill to full, refuse a fifth, then full-with-dequeue and wrap.
        applyStimulus(1, 8'hC0, 4'b0000);
        applyStimulus(1, 8'h81, 4'b0000);
        applyStimulus(1, 8'h02, 4'b0000);
        applyStimulus(1, 8'h43, 4'b0000);
        applyStimulus(1, 8'hFF, 4'b0000);
        applyStimulus(1, 8'h11, 4'b1111);
        applyStimulus(1, 8'h11, 4'b0000);
        for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 4'b1111);

        // Head-of-line blocking: head for output 2, next entry for output 0.
        applyStimulus(1, 8'h80, 4'b0000);
        applyStimulus(1, 8'h00, 4'b1011);
        for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 4'b1011);
        applyStimulus(0, 8'h00, 4'b0100);
        applyStimulus(0, 8'h00, 4'b1111);
        applyStimulus(0, 8'h00, 4'b1111);

        // Reset with three entries queued discards them.
        applyStimulus(1, 8'h01, 4'b0000);
        applyStimulus(1, 8'h42, 4'b0000);
        applyStimulus(1, 8'h83, 4'b0000);
        doReset();
        applyStimulus(0, 8'h00, 4'b1111);
        applyStimulus(1, 8'h40, 4'b0010);
        applyStimulus(0, 8'h00, 4'b0010);
        applyStimulus(0, 8'h00, 4'b0000);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                doReset();
            end else begin
                applyStimulus(bit'($urandom_range(0, 2) != 0), 8'($urandom),
                              ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom));
            end
        end

        // Drain everything that is still queued.
        for (int i = 0; i < 8; i++) applyStimulus(0, 8'h00, 4'b1111);
        monitorOn = 1'b0;
        checkOutput("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_dispatch_queue.md
Name: router_dispatch_queue

Overview:
Input-side buffering and dispatch stage that sits directly upstream of the router's parametric demux.
- Accepts a val/rdy message stream and queues messages in a circular FIFO.
- Extracts the destination index from the message's top bits.
- Presents head-of-queue message plus select to the demux; dequeues only when the addressed output's ready is high.

Parameters:
p_nbits, 32, message width in bits; must be > $clog2(p_noutputs)
p_noutputs, 8, number of demux outputs; must be >= 2
p_depth, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
recv_msg  input  p_nbits  incoming message; destination = recv_msg[p_nbits-1 -: $clog2(p_noutputs)]
recv_val  input  1  upstream valid
recv_rdy  output  1  queue can accept
send_msg  output  p_nbits  head message to demux in_val
send_sel  output  $clog2(p_noutputs)  head destination to demux sel
send_val  output  1  head valid
send_rdy  input  p_noutputs  per-output ready from downstream consumers
count  output  $clog2(p_depth)+1  current occupancy

Behaviour:
- Reset (reset==0 at posedge):
  - head ptr, tail ptr and count cleared to 0.
  - Outputs after reset: recv_rdy=1, send_val=0, send_msg=0, send_sel=0, count=0.
  - Reset mid-operation discards all queued entries. Storage contents need not be cleared.
- Enqueue fires when recv_val && recv_rdy: write recv_msg at tail, tail = tail+1 mod p_depth.
- recv_rdy = (count != p_depth). It depends only on registered state, never combinationally on send_rdy.
- Head outputs:
  - send_val = (count != 0).
  - When empty, send_msg=0 and send_sel=0, so the demux drives all-zero outputs.
  - When non-empty, send_msg = entry[head] and send_sel = top $clog2(p_noutputs) bits of entry[head].
- Dequeue fires when send_val && send_rdy[send_sel]: head = head+1 mod p_depth.
- If send_sel >= p_noutputs (non-power-of-two p_noutputs), treat as not ready. The entry stalls forever; this is a documented software error and is not dropped.
- Head-of-line blocking: a stalled head blocks all later entries, even those whose outputs are ready. No reordering.
- Latency: a message enqueued at posedge N is visible on send_* after posedge N (earliest dequeue at posedge N+1). Minimum 1 cycle.
- Simultaneous events:
  - Enq and deq in the same cycle: count unchanged, both pointers advance.
  - Full with dequeue: enqueue still refused that cycle (recv_rdy=0); space appears next cycle.
  - Empty with enqueue: no dequeue that cycle (without bypass).
- count update: +1 on enq only, -1 on deq only, unchanged otherwise. Never exceeds p_depth, never underflows.
- Pointer wrap: pointers are $clog2(p_depth) bits and wrap naturally.

Optional Feature:
ROUTER_DISPATCH_BYPASS_EN
- Defined: when count==0 and recv_val==1, send_val=1, send_msg=recv_msg, and send_sel is taken from recv_msg, all combinationally.
  - If send_rdy[that sel] is also 1, the message passes through with zero latency and is not written; count stays 0.
  - Otherwise it is written normally.
  - recv_rdy is unchanged (still count-based).
- Undefined: no combinational recv→send path; minimum latency 1 cycle as above.

Test Plan:
All scenarios use p_nbits=8, p_noutputs=4, p_depth=4; destination = msg[7:6].
- Reset then idle -> recv_rdy=1, send_val=0, send_msg=0x00, send_sel=0, count=0.
- Enqueue 0x41 with send_rdy=4'b0000, then raise send_rdy=4'b0010 -> send_sel=1, send_msg=0x41 held while stalled; dequeued on the first edge with send_rdy[1]=1; count 1->0.
- Enqueue 0xC0,0x81,0x02,0x43 with send_rdy=0 -> count=4, recv_rdy=0; a fifth recv_val=1 with 0xFF is not accepted; then send_rdy=4'b1111 drains in order C0,81,02,43 (sel 3,2,0,1).
- Full queue, send_rdy=4'b1111 and recv_val=1 with 0x11 the same cycle -> one dequeue, no enqueue; next cycle recv_rdy=1 and 0x11 accepted; order preserved across pointer wrap.
- Head 0x80 (sel 2) with send_rdy=4'b1011, second entry 0x00 -> nothing dequeues (HOL blocking) until send_rdy[2]=1.
- Queue with count=3, assert reset=0 for one cycle -> count=0, send_val=0, recv_rdy=1; with BYPASS_EN, empty + recv 0x40 + send_rdy=4'b0010 -> send_val=1 same cycle, count stays 0.
